// File: rtl/imem_pkg.sv
// Shared constants and types for the loadable instruction memory.
// The state and fault-cause encodings are visible on the ports and in the bench.
package imem_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NONE       = 2'b00,
        MISALIGNED = 2'b01,
        RANGE      = 2'b10
    } fault_cause_e;

    // Expands a per-lane enable into a 32-bit byte mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] lane_en);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{lane_en[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// Byte-lane instruction store: four independent 8-bit lanes with per-lane write
// enables and a registered 32-bit read port that holds its value when idle.
module imem_byte_ram #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = 6
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_q;

        // NOTE: the array has no reset; stale contents are hidden by the loaded-length mask in the top.
        always_ff @(posedge clk) begin
            if (i_we[lane]) begin
                r_mem[i_waddr] <= i_wdata;
            end
            if (i_re) begin
                r_q <= r_mem[i_raddr];
            end
        end

        assign o_rdata[8*lane +: 8] = r_q;
    end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: byte-stream image load after reset, then
// word-aligned fetches with a one-cycle registered read and fault reporting.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] NOP_WORD    = imem_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_done,
    output logic        load_ready,
    output logic        load_overflow,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause
);

    localparam int unsigned CAP_BYTES = 4 * DEPTH_WORDS;
    localparam int unsigned BP_W      = $clog2(CAP_BYTES + 1);
    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [BP_W-1:0] CAP_BP   = BP_W'(CAP_BYTES);
    localparam logic [31:0]     CAP_ADDR = 32'(CAP_BYTES);

    state_e          r_state;
    state_e          w_state_next;
    logic            r_load_ready;
    logic            r_fetch_ready;
    logic            r_load_overflow;
    logic [BP_W-1:0] r_bp;

    logic            w_load_accept;
    logic            w_byte_wr;
    logic [3:0]      w_we;

    logic            w_fetch_accept;
    fault_cause_e    w_cause;
    logic [31:0]     w_word_base;
    logic [31:0]     w_len;
    logic [3:0]      w_lane_en;

    logic            r_instr_valid;
    logic            r_rsp_fault;
    fault_cause_e    r_rsp_cause;
    logic [3:0]      r_rsp_lane_en;
    logic [31:0]     w_rdata;

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (r_state == LOAD && load_done) begin
            w_state_next = RUN;
        end
    end

    // Handshake flags are registered so both read 0 in the cycle right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_ready  <= 1'b0;
            r_fetch_ready <= 1'b0;
        end else begin
            r_load_ready  <= (w_state_next == LOAD);
            r_fetch_ready <= (w_state_next == RUN);
        end
    end

    // ---------------- image load ----------------
    assign w_load_accept = load_valid && r_load_ready && !reset;
    assign w_byte_wr     = w_load_accept && (r_bp != CAP_BP);
    assign w_we          = w_byte_wr ? (4'b0001 << r_bp[1:0]) : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bp            <= '0;
            r_load_overflow <= 1'b0;
        end else begin
            if (w_byte_wr) begin
                r_bp <= r_bp + BP_W'(1);
            end
            if (w_load_accept && (r_bp == CAP_BP)) begin
                r_load_overflow <= 1'b1;
            end
        end
    end

    // ---------------- fetch ----------------
    assign w_fetch_accept = fetch_req && r_fetch_ready && !reset;

    always_comb begin
        w_cause = NONE;
        if (fetch_addr[1:0] != 2'b00) begin
            w_cause = MISALIGNED;
        end else if (fetch_addr >= CAP_ADDR) begin
            w_cause = RANGE;
        end
    end

    // A lane is live only if its byte address lies below the loaded length.
    assign w_word_base = {fetch_addr[31:2], 2'b00};
    assign w_len       = 32'(r_bp);

    always_comb begin
        w_lane_en = '0;
        for (int k = 0; k < 4; k++) begin
            w_lane_en[k] = (w_word_base + 32'(k)) < w_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_valid <= 1'b0;
            r_rsp_fault   <= 1'b0;
            r_rsp_cause   <= NONE;
            r_rsp_lane_en <= '0;
        end else begin
            r_instr_valid <= w_fetch_accept;
            if (w_fetch_accept) begin
                r_rsp_fault   <= (w_cause != NONE);
                r_rsp_cause   <= w_cause;
                r_rsp_lane_en <= w_lane_en;
            end
        end
    end

    imem_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_bp[AW+1:2]),
        .i_wdata (load_byte),
        .i_re    (w_fetch_accept),
        .i_raddr (fetch_addr[AW+1:2]),
        .o_rdata (w_rdata)
    );

    // Unloaded words (lane 0 dead) and faults both return the NOP word.
    assign instr = (r_rsp_fault || !r_rsp_lane_en[0])
                 ? NOP_WORD
                 : (w_rdata & lane_mask(r_rsp_lane_en));

    assign load_ready    = r_load_ready;
    assign load_overflow = r_load_overflow;
    assign fetch_ready   = r_fetch_ready;
    assign instr_valid   = r_instr_valid;
    assign fetch_fault   = r_rsp_fault;
    assign fault_cause   = r_rsp_cause;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: a 64-word instance for load/fetch/fault/reset
// scenarios and a 4-word instance for the capacity-overflow boundary.
module tb_imem_loadable;

    localparam int unsigned DA  = 64;
    localparam int unsigned DB  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
        logic [1:0]  cause;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset = 1'b1, a_load_valid = 1'b0, a_load_done = 1'b0, a_fetch_req = 1'b0;
    logic [7:0]  a_load_byte = '0;
    logic [31:0] a_fetch_addr = '0;
    logic        a_load_ready, a_load_overflow, a_fetch_ready, a_instr_valid, a_fetch_fault;
    logic [31:0] a_instr;
    logic [1:0]  a_fault_cause;

    logic        b_reset = 1'b1, b_load_valid = 1'b0, b_load_done = 1'b0, b_fetch_req = 1'b0;
    logic [7:0]  b_load_byte = '0;
    logic [31:0] b_fetch_addr = '0;
    logic        b_load_ready, b_load_overflow, b_fetch_ready, b_instr_valid, b_fetch_fault;
    logic [31:0] b_instr;
    logic [1:0]  b_fault_cause;

    imem_loadable #(.DEPTH_WORDS(DA), .NOP_WORD(NOP)) u_dut_a (
        .clk(clk), .reset(a_reset),
        .load_valid(a_load_valid), .load_byte(a_load_byte), .load_done(a_load_done),
        .load_ready(a_load_ready), .load_overflow(a_load_overflow),
        .fetch_req(a_fetch_req), .fetch_addr(a_fetch_addr), .fetch_ready(a_fetch_ready),
        .instr(a_instr), .instr_valid(a_instr_valid),
        .fetch_fault(a_fetch_fault), .fault_cause(a_fault_cause)
    );

    imem_loadable #(.DEPTH_WORDS(DB), .NOP_WORD(NOP)) u_dut_b (
        .clk(clk), .reset(b_reset),
        .load_valid(b_load_valid), .load_byte(b_load_byte), .load_done(b_load_done),
        .load_ready(b_load_ready), .load_overflow(b_load_overflow),
        .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_ready(b_fetch_ready),
        .instr(b_instr), .instr_valid(b_instr_valid),
        .fetch_fault(b_fetch_fault), .fault_cause(b_fault_cause)
    );

    int checks   = 0;
    int failures = 0;

    rsp_t       sb_q[$];
    logic [7:0] img [4*DA];
    int         img_len = 0;

    // Reference behaviour of the 64-word instance for the image loaded so far.
    function automatic rsp_t model_fetch(input logic [31:0] addr);
        rsp_t r;
        r.instr = NOP;
        r.fault = 1'b0;
        r.cause = 2'b00;
        if (addr[1:0] != 2'b00) begin
            r.fault = 1'b1;
            r.cause = 2'b01;
        end else if (addr >= 32'(4*DA)) begin
            r.fault = 1'b1;
            r.cause = 2'b10;
        end else if (addr < 32'(img_len)) begin
            for (int k = 0; k < 4; k++) begin
                r.instr[8*k +: 8] = (int'(addr) + k < img_len) ? img[int'(addr) + k] : 8'h00;
            end
        end
        return r;
    endfunction

    task automatic reset_a();
        a_reset = 1'b1; a_load_valid = 1'b0; a_load_done = 1'b0; a_fetch_req = 1'b0;
        @(posedge clk); #1;
        a_reset = 1'b0;
        sb_q.delete();
        img_len = 0;
        @(posedge clk); #1;
    endtask

    task automatic load_a(input logic [7:0] bytes [8], input int n, input bit done_on_last);
        for (int i = 0; i < n; i++) begin
            a_load_valid = 1'b1;
            a_load_byte  = bytes[i];
            a_load_done  = done_on_last && (i == n - 1);
            if (img_len < 4*DA) begin
                img[img_len] = bytes[i];
                img_len++;
            end
            @(posedge clk); #1;
        end
        a_load_valid = 1'b0;
        a_load_done  = 1'b0;
        if (!done_on_last || n == 0) begin
            a_load_done = 1'b1;
            @(posedge clk); #1;
            a_load_done = 1'b0;
        end
    endtask

    // Issues n back-to-back fetches; expectations pushed on issue, popped on instr_valid.
    task automatic fetch_seq(input string tag, input logic [31:0] addrs [8], input int n);
        bit   prev;
        rsp_t exp;
        prev = 1'b0;
        for (int i = 0; i <= n; i++) begin
            checks++;
            if (a_instr_valid !== prev) begin
                failures++;
                $display("FAIL %s_valid slot=%0d actual=%b required=%b", tag, i, a_instr_valid, prev);
            end
            if (prev && a_instr_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_sb slot=%0d actual=response required=empty_queue", tag, i);
                end else begin
                    exp = sb_q.pop_front();
                    if ({a_instr, a_fetch_fault, a_fault_cause} !== exp) begin
                        failures++;
                        $display("FAIL %s_rsp slot=%0d actual=%h/%b/%b required=%h/%b/%b", tag, i,
                                 a_instr, a_fetch_fault, a_fault_cause, exp.instr, exp.fault, exp.cause);
                    end
                end
            end
            if (i < n) begin
                a_fetch_req  = 1'b1;
                a_fetch_addr = addrs[i];
                sb_q.push_back(model_fetch(addrs[i]));
            end else begin
                a_fetch_req = 1'b0;
            end
            prev = (i < n);
            @(posedge clk); #1;
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({a_load_ready, a_load_overflow, a_fetch_ready, a_instr, a_instr_valid, a_fetch_fault, a_fault_cause}
            !== {1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 2'b00}) begin
            failures++;
            $display("FAIL reset_outputs actual=%b%b%b %h %b%b%b required=000 %h 0000", a_load_ready,
                     a_load_overflow, a_fetch_ready, a_instr, a_instr_valid, a_fetch_fault, a_fault_cause, NOP);
        end
        a_reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_load_ready !== 1'b1 || a_fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release actual=%b%b required=10", a_load_ready, a_fetch_ready);
        end
    endtask

    task automatic test_fetch_in_load();
        for (int i = 0; i < 3; i++) begin
            a_fetch_req  = 1'b1;
            a_fetch_addr = 32'(4*i);
            @(posedge clk); #1;
            checks++;
            if (a_instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL load_fetch_ignored cycle=%0d actual=%b required=0", i, a_instr_valid);
            end
        end
        a_fetch_req = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0]  prog  [8] = '{8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00};
        logic [31:0] addrs [8] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        load_a(prog, 8, 1'b1);
        checks++;
        if (a_load_ready !== 1'b0 || a_fetch_ready !== 1'b1 || a_load_overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_mode actual=%b%b%b required=010", a_load_ready, a_fetch_ready, a_load_overflow);
        end
        fetch_seq("basic", addrs, 4);
    endtask

    task automatic test_faults();
        logic [31:0] addrs [8] = '{32'h2, 32'h100, 32'h101, 32'h3, 32'hFFFF_FFFC, 32'h4, 32'hFC, 32'h0};
        fetch_seq("fault", addrs, 8);
    endtask

    task automatic test_load_in_run();
        logic [31:0] addrs [8] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            a_load_valid = 1'b1;
            a_load_byte  = 8'hFF;
            @(posedge clk); #1;
            checks++;
            if (a_load_ready !== 1'b0) begin
                failures++;
                $display("FAIL run_load_ready cycle=%0d actual=%b required=0", i, a_load_ready);
            end
        end
        a_load_valid = 1'b0;
        fetch_seq("run_load", addrs, 2);
    endtask

    task automatic test_partial_stale();
        logic [7:0]  old_img [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        logic [7:0]  prog    [8] = '{8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h0B, 8'hEE, 8'hEE};
        logic [31:0] addrs   [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0};
        reset_a();
        load_a(old_img, 8, 1'b0);
        reset_a();
        load_a(prog, 6, 1'b0);
        fetch_seq("partial", addrs, 4);
    endtask

    task automatic test_overflow();
        rsp_t        q[$];
        rsp_t        exp;
        logic [31:0] baddr [3] = '{32'hC, 32'h0, 32'h10};
        rsp_t        bexp  [3] = '{'{32'h1F1E_1D1C, 1'b0, 2'b00},
                                   '{32'h1312_1110, 1'b0, 2'b00},
                                   '{NOP, 1'b1, 2'b10}};
        b_reset = 1'b1;
        @(posedge clk); #1;
        b_reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            b_load_valid = 1'b1;
            b_load_byte  = 8'h10 + i[7:0];
            @(posedge clk); #1;
            if (i == 15) begin
                checks++;
                if (b_load_overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_at_capacity actual=%b required=0", b_load_overflow);
                end
            end
        end
        b_load_valid = 1'b0;
        checks++;
        if (b_load_overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set actual=%b required=1", b_load_overflow);
        end
        b_load_done = 1'b1;
        @(posedge clk); #1;
        b_load_done = 1'b0;
        checks++;
        if (b_load_overflow !== 1'b1 || b_fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky actual=%b%b required=11", b_load_overflow, b_fetch_ready);
        end
        for (int i = 0; i <= 3; i++) begin
            if (b_instr_valid === 1'b1) begin
                checks++;
                exp = (q.size() != 0) ? q.pop_front() : '0;
                if ({b_instr, b_fetch_fault, b_fault_cause} !== exp) begin
                    failures++;
                    $display("FAIL ovf_rsp slot=%0d actual=%h/%b/%b required=%h/%b/%b", i,
                             b_instr, b_fetch_fault, b_fault_cause, exp.instr, exp.fault, exp.cause);
                end
            end else if (i > 0) begin
                checks++;
                failures++;
                $display("FAIL ovf_valid slot=%0d actual=0 required=1", i);
            end
            if (i < 3) begin
                b_fetch_req  = 1'b1;
                b_fetch_addr = baddr[i];
                q.push_back(bexp[i]);
            end else begin
                b_fetch_req = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_inflight();
        logic [7:0]  prog  [8] = '{8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00};
        logic [7:0]  junk  [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0, 8'h0, 8'h0, 8'h0};
        logic [31:0] addrs [8] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        // Reset with a fetch in flight.
        a_fetch_req  = 1'b1;
        a_fetch_addr = 32'h0;
        @(posedge clk); #1;
        checks++;
        if (a_instr_valid !== 1'b1 || a_instr !== 32'h0040_0093) begin
            failures++;
            $display("FAIL pre_reset_rsp actual=%b/%h required=1/00400093", a_instr_valid, a_instr);
        end
        a_fetch_addr = 32'h4;
        a_reset      = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a_instr_valid, a_instr, a_fetch_fault, a_fault_cause, a_load_ready, a_fetch_ready}
            !== {1'b0, NOP, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_fetch actual=%b/%h/%b/%b/%b%b required=0/%h/0/00/00", a_instr_valid,
                     a_instr, a_fetch_fault, a_fault_cause, a_load_ready, a_fetch_ready, NOP);
        end
        a_reset     = 1'b0;
        a_fetch_req = 1'b0;
        sb_q.delete();
        img_len = 0;
        @(posedge clk); #1;
        checks++;
        if (a_load_ready !== 1'b1 || a_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_fetch_reload actual=%b%b required=10", a_load_ready, a_instr_valid);
        end
        // Reset in the middle of a load.
        for (int i = 0; i < 2; i++) begin
            a_load_valid = 1'b1;
            a_load_byte  = junk[i];
            @(posedge clk); #1;
        end
        a_reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_load_ready !== 1'b0 || a_load_overflow !== 1'b0 || a_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_load actual=%b%b%b required=000", a_load_ready, a_load_overflow, a_instr_valid);
        end
        a_reset      = 1'b0;
        a_load_valid = 1'b0;
        img_len      = 0;
        @(posedge clk); #1;
        load_a(junk, 0, 1'b0);
        fetch_seq("stale", addrs, 2);
        reset_a();
        load_a(prog, 8, 1'b1);
        fetch_seq("reload", addrs, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch_in_load();
        test_basic();
        test_faults();
        test_load_in_run();
        test_partial_stale();
        test_overflow();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
